bootctrl_mh_regbus: RTL and testbench



---
 rtl/bootctrl_mh_regbus.sv | 269 ++++++++++++++++++++++++++
 tb/tb_bootctrl_mh_regbus.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/bootctrl_mh_regbus.sv
// Multi-hart boot controller on the regbus: per-hart reset/run sequencing,
// boot vectors, last-PC readback and an optional PC-trace FIFO.
// Ports: ACLK/ARESET (async, active-high); regbus WRADDR/BYTEEN/WREN/WDATA,
// RDADDR/RDEN/RDATA (registered); hart_reset/hart_run/hart_dram_base/
// hart_entry_pc to the cores; hart_last_pc/hart_pc_valid from the cores.
// Build option: define BOOTCTRL_MH_TRACE_EN to include the trace FIFO.
module bootctrl_mh_regbus #(
  parameter int          NHARTS         = 2,
  parameter logic [15:0] BOOT_BASE      = 16'h1000,
  parameter int          RELEASE_CYCLES = 8,
  parameter int          TRACE_DEPTH    = 16
) (
  input  logic                   ACLK,
  input  logic                   ARESET,
  input  logic [15:0]            WRADDR,
  input  logic [3:0]             BYTEEN,
  input  logic                   WREN,
  input  logic [31:0]            WDATA,
  input  logic [15:0]            RDADDR,
  input  logic                   RDEN,
  output logic [31:0]            RDATA,
  output logic [NHARTS-1:0]      hart_reset,
  output logic [NHARTS-1:0]      hart_run,
  output logic [NHARTS*32-1:0]   hart_dram_base,
  output logic [NHARTS*32-1:0]   hart_entry_pc,
  input  logic [NHARTS*32-1:0]   hart_last_pc,
  input  logic [NHARTS-1:0]      hart_pc_valid
);
  localparam int CW = $clog2(RELEASE_CYCLES + 1);
  localparam int AW = $clog2(TRACE_DEPTH);

  typedef enum logic [1:0] {
    ST_HOLD  = 2'd0,
    ST_REL   = 2'd1,
    ST_READY = 2'd2,
    ST_RUN   = 2'd3
  } hstate_t;

  function automatic logic [31:0] bmerge(
    input logic [31:0] o,
    input logic [31:0] n,
    input logic [3:0]  be
  );
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++)
      if (be[b]) r[b*8 +: 8] = n[b*8 +: 8];
    return r;
  endfunction

  logic [15:0] wrel, rrel;
  logic        wwin, rwin;
  assign wrel = WRADDR - BOOT_BASE;
  assign rrel = RDADDR - BOOT_BASE;
  assign wwin = (wrel[15:8] == 8'h01) && (wrel[1:0] == 2'b00);
  assign rwin = (rrel[15:8] == 8'h01) && (rrel[1:0] == 2'b00);

  hstate_t     st_q   [NHARTS];
  hstate_t     st_d   [NHARTS];
  logic [CW-1:0] cnt_q [NHARTS];
  logic [CW-1:0] cnt_d [NHARTS];
  logic        pend_q [NHARTS];
  logic        pend_d [NHARTS];
  logic        err_q  [NHARTS];
  logic        err_d  [NHARTS];
  logic [31:0] dram_q [NHARTS];
  logic [31:0] entry_q[NHARTS];

  always_comb begin
    logic ctrl_wr;
    ctrl_wr = 1'b0;
    for (int h = 0; h < NHARTS; h++) begin
      st_d[h]   = st_q[h];
      cnt_d[h]  = cnt_q[h];
      pend_d[h] = pend_q[h];
      err_d[h]  = err_q[h];
      ctrl_wr   = WREN && BYTEEN[0] && wwin &&
                  (int'(wrel[7:5]) == h) && (wrel[4:0] == 5'h04);
      if (st_q[h] == ST_REL) begin
        if (cnt_q[h] <= CW'(1)) begin
          st_d[h]   = pend_q[h] ? ST_RUN : ST_READY;
          cnt_d[h]  = '0;
          pend_d[h] = 1'b0;
        end else begin
          cnt_d[h] = cnt_q[h] - CW'(1);
        end
      end
      if (ctrl_wr) begin
        if (WDATA[3]) err_d[h] = 1'b0;
        if (WDATA[0]) begin
          st_d[h]   = ST_HOLD;
          cnt_d[h]  = '0;
          pend_d[h] = 1'b0;
          if (WDATA[1] && st_q[h] == ST_HOLD) err_d[h] = 1'b1;
        end else begin
          unique case (st_q[h])
            ST_HOLD: begin
              st_d[h]   = ST_REL;
              cnt_d[h]  = CW'(RELEASE_CYCLES);
              pend_d[h] = WDATA[1];
            end
            ST_REL: begin
              // a START landing on the expiry cycle goes straight to run
              if (WDATA[1]) begin
                if (cnt_q[h] <= CW'(1)) st_d[h] = ST_RUN;
                else pend_d[h] = 1'b1;
              end
            end
            ST_READY: if (WDATA[1]) st_d[h] = ST_RUN;
            ST_RUN:   if (WDATA[2]) st_d[h] = ST_READY;
          endcase
        end
      end
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      for (int h = 0; h < NHARTS; h++) begin
        st_q[h]    <= ST_HOLD;
        cnt_q[h]   <= '0;
        pend_q[h]  <= 1'b0;
        err_q[h]   <= 1'b0;
        dram_q[h]  <= '0;
        entry_q[h] <= '0;
      end
    end else begin
      for (int h = 0; h < NHARTS; h++) begin
        st_q[h]   <= st_d[h];
        cnt_q[h]  <= cnt_d[h];
        pend_q[h] <= pend_d[h];
        err_q[h]  <= err_d[h];
        if (WREN && wwin && int'(wrel[7:5]) == h) begin
          if (wrel[4:0] == 5'h08)
            dram_q[h] <= bmerge(dram_q[h], WDATA, BYTEEN);
          if (wrel[4:0] == 5'h0C)
            entry_q[h] <= bmerge(entry_q[h], WDATA, BYTEEN);
        end
      end
    end
  end

  always_comb begin
    for (int h = 0; h < NHARTS; h++) begin
      hart_reset[h] = (st_q[h] == ST_HOLD) || (st_q[h] == ST_REL);
      hart_run[h]   = (st_q[h] == ST_RUN);
      hart_dram_base[h*32 +: 32] = dram_q[h];
      hart_entry_pc[h*32 +: 32]  = entry_q[h];
    end
  end

  logic [AW:0]  tr_count;
  logic         tr_empty;
  logic         tr_ovf;
  logic [31:0]  tr_ctrl_rd;
  logic [31:0]  tr_data;

`ifdef BOOTCTRL_MH_TRACE_EN
  logic         tr_en_q;
  logic [2:0]   tr_sel_q;
  logic [31:0]  mem [TRACE_DEPTH];
  logic [AW:0]  wp_q, rp_q;
  logic         first_q;
  logic [31:0]  last_q;
  logic [31:0]  s_pc;
  logic         s_v;
  logic         cap, push, drop, pop, tctrl_wr, clear;

  always_comb begin
    s_pc = '0;
    s_v  = 1'b0;
    for (int h = 0; h < NHARTS; h++)
      if (int'(tr_sel_q) == h) begin
        s_pc = hart_last_pc[h*32 +: 32];
        s_v  = hart_pc_valid[h];
      end
  end

  assign tr_count   = wp_q - rp_q;
  assign tr_empty   = (tr_count == '0);
  assign cap        = tr_en_q && s_v && (first_q || s_pc != last_q);
  assign push       = cap && (tr_count != (AW+1)'(TRACE_DEPTH));
  assign drop       = cap && !push;
  assign pop        = RDEN && (rrel == 16'h0018) && !tr_empty;
  assign tctrl_wr   = WREN && BYTEEN[0] && (wrel == 16'h0010);
  assign clear      = tctrl_wr && WDATA[8];
  assign tr_ctrl_rd = {28'b0, tr_sel_q, tr_en_q};
  assign tr_data    = tr_empty ? 32'h0 : mem[rp_q[AW-1:0]];

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      tr_en_q  <= 1'b0;
      tr_sel_q <= '0;
      wp_q     <= '0;
      rp_q     <= '0;
      tr_ovf   <= 1'b0;
      first_q  <= 1'b1;
      last_q   <= '0;
    end else begin
      if (clear) begin
        wp_q    <= '0;
        rp_q    <= '0;
        tr_ovf  <= 1'b0;
        first_q <= 1'b1;
      end else begin
        if (push) begin
          wp_q    <= wp_q + 1'b1;
          last_q  <= s_pc;
          first_q <= 1'b0;
        end
        if (drop) tr_ovf <= 1'b1;
        if (pop) rp_q <= rp_q + 1'b1;
      end
      if (tctrl_wr) begin
        tr_en_q  <= WDATA[0];
        tr_sel_q <= WDATA[3:1];
        if (WDATA[3:1] != tr_sel_q) first_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge ACLK)
    if (push && !clear) mem[wp_q[AW-1:0]] <= s_pc;
`else
  logic unused_trace;
  assign unused_trace = ^hart_pc_valid;
  assign tr_count     = '0;
  assign tr_empty     = 1'b1;
  assign tr_ovf       = 1'b0;
  assign tr_ctrl_rd   = '0;
  assign tr_data      = '0;
`endif

  logic [31:0] rd_mux;
  logic [7:0]  run_v, hold_v;

  always_comb begin
    rd_mux = '0;
    run_v  = '0;
    hold_v = '0;
    for (int h = 0; h < NHARTS; h++) begin
      run_v[h]  = (st_q[h] == ST_RUN);
      hold_v[h] = (st_q[h] == ST_HOLD);
    end
    if (rrel == 16'h0000)
      rd_mux = {14'b0, tr_empty, tr_ovf, hold_v, run_v};
    if (rrel == 16'h0010) rd_mux = tr_ctrl_rd;
    if (rrel == 16'h0014) rd_mux = 32'(tr_count);
    if (rrel == 16'h0018) rd_mux = tr_data;
    for (int h = 0; h < NHARTS; h++)
      if (rwin && int'(rrel[7:5]) == h) begin
        case (rrel[4:0])
          5'h00: rd_mux = {27'b0, err_q[h], st_q[h],
                           hold_v[h], run_v[h]};
          5'h04: rd_mux = {31'b0, hold_v[h]};
          5'h08: rd_mux = dram_q[h];
          5'h0C: rd_mux = entry_q[h];
          5'h10: rd_mux = hart_last_pc[h*32 +: 32];
          default: rd_mux = '0;
        endcase
      end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) RDATA <= '0;
    else if (RDEN) RDATA <= rd_mux;
  end

endmodule

// File: tb/tb_bootctrl_mh_regbus.sv
// Self-checking bench for bootctrl_mh_regbus: register table vectors plus
// directed sequences for release timing, stop/hold, reset and trace FIFO.
module tb_bootctrl_mh_regbus;
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] wraddr, rdaddr;
  logic [3:0]  byteen;
  logic        wren, rden;
  logic [31:0] wdata, rdata;
  logic [1:0]  hreset, hrun;
  logic [63:0] dbase, epc, lpc;
  logic [1:0]  pcv;

  int nchk = 0;
  int nerr = 0;

  bootctrl_mh_regbus dut (
    .ACLK(clk), .ARESET(rst),
    .WRADDR(wraddr), .BYTEEN(byteen), .WREN(wren), .WDATA(wdata),
    .RDADDR(rdaddr), .RDEN(rden), .RDATA(rdata),
    .hart_reset(hreset), .hart_run(hrun),
    .hart_dram_base(dbase), .hart_entry_pc(epc),
    .hart_last_pc(lpc), .hart_pc_valid(pcv)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rd;
    logic [15:0] addr;
    logic [3:0]  be;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[20];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic wr(input logic [15:0] a, input logic [3:0] be,
                    input logic [31:0] d);
    wraddr = a; byteen = be; wdata = d; wren = 1'b1;
    @(negedge clk);
    wren = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a, output logic [31:0] d);
    rdaddr = a; rden = 1'b1;
    @(negedge clk);
    rden = 1'b0;
    d = rdata;
  endtask

  task automatic rdchk(input string nm, input logic [15:0] a,
                       input logic [31:0] exp);
    logic [31:0] d;
    rd(a, d);
    chk(nm, d, exp);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    int n;
    logic [31:0] pcs[4];
    tbl[0]  = '{1, 16'h1000, 4'h0, 32'h0, 32'h0002_0300};
    tbl[1]  = '{1, 16'h1100, 4'h0, 32'h0, 32'h0000_0002};
    tbl[2]  = '{1, 16'h1104, 4'h0, 32'h0, 32'h0000_0001};
    tbl[3]  = '{0, 16'h1108, 4'h5, 32'hAABB_CCDD, 32'h0};
    tbl[4]  = '{1, 16'h1108, 4'h0, 32'h0, 32'h00BB_00DD};
    tbl[5]  = '{0, 16'h1108, 4'hA, 32'h1122_3344, 32'h0};
    tbl[6]  = '{1, 16'h1108, 4'h0, 32'h0, 32'h11BB_33DD};
    tbl[7]  = '{1, 16'h1110, 4'h0, 32'h0, 32'h3333_4444};
    tbl[8]  = '{1, 16'h1130, 4'h0, 32'h0, 32'h1111_2222};
    tbl[9]  = '{1, 16'h1140, 4'h0, 32'h0, 32'h0};
    tbl[10] = '{1, 16'h1114, 4'h0, 32'h0, 32'h0};
    tbl[11] = '{1, 16'h0100, 4'h0, 32'h0, 32'h0};
    tbl[12] = '{0, 16'h1104, 4'hE, 32'h0, 32'h0};
    tbl[13] = '{1, 16'h1100, 4'h0, 32'h0, 32'h0000_0002};
    tbl[14] = '{0, 16'h1104, 4'hF, 32'h3, 32'h0};
    tbl[15] = '{1, 16'h1100, 4'h0, 32'h0, 32'h0000_0012};
    tbl[16] = '{0, 16'h1104, 4'hF, 32'h9, 32'h0};
    tbl[17] = '{1, 16'h1100, 4'h0, 32'h0, 32'h0000_0002};
    tbl[18] = '{0, 16'h1100, 4'hF, 32'hFFFF_FFFF, 32'h0};
    tbl[19] = '{1, 16'h1100, 4'h0, 32'h0, 32'h0000_0002};

    rst = 1'b1; wren = 0; rden = 0; wraddr = 0; rdaddr = 0;
    byteen = 0; wdata = 0; pcv = 0;
    lpc = {32'h1111_2222, 32'h3333_4444};
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_hart_reset", 32'(hreset), 32'h3);
    chk("rst_hart_run", 32'(hrun), 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_dram", dbase[31:0], 32'h0);

    for (int i = 0; i < 20; i++) begin
      if (tbl[i].rd) begin
        rd(tbl[i].addr, d);
        chk($sformatf("tbl%0d", i), d, tbl[i].exp);
      end else begin
        wr(tbl[i].addr, tbl[i].be, tbl[i].data);
      end
    end
    chk("hold_rdata", rdata, 32'h2);
    chk("dram0_out", dbase[31:0], 32'h11BB_33DD);

    wr(16'h1128, 4'hF, 32'h2000_0000);
    wr(16'h112C, 4'hF, 32'h0000_0100);
    chk("dram1_out", dbase[63:32], 32'h2000_0000);
    chk("entry1_out", epc[63:32], 32'h0000_0100);
    wr(16'h1124, 4'hF, 32'h2);
    n = 0;
    while (hreset[1] && n < 20) begin
      chk("run1_early", 32'(hrun[1]), 32'h0);
      @(negedge clk);
      n++;
    end
    chk("release_cycles", n, 8);
    chk("run1_rise", 32'(hrun[1]), 32'h1);
    chk("hart0_untouched", {30'b0, hreset[0], hrun[0]}, 32'h2);
    rdchk("h1_status_run", 16'h1120, 32'h0000_000D);
    rdchk("gstat_h1run", 16'h1000, 32'h0002_0102);

    wr(16'h1124, 4'hF, 32'h4);
    rdchk("h1_stop", 16'h1120, 32'h0000_0008);
    wr(16'h1124, 4'hF, 32'h2);
    rdchk("h1_restart", 16'h1120, 32'h0000_000D);
    wr(16'h1124, 4'hF, 32'h1);
    chk("h1_hold_run", 32'(hrun[1]), 32'h0);
    chk("h1_hold_rst", 32'(hreset[1]), 32'h1);
    rdchk("h1_hold_stat", 16'h1120, 32'h0000_0002);

    wr(16'h1104, 4'hF, 32'h0);
    @(negedge clk);
    @(negedge clk);
    wr(16'h1104, 4'hF, 32'h2);
    n = 0;
    while (hreset[0] && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("pend_cycles", n, 5);
    chk("pend_run", 32'(hrun[0]), 32'h1);
    rdchk("gstat_mix", 16'h1000, 32'h0002_0201);

    wr(16'h1124, 4'hF, 32'h0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_reset", 32'(hreset), 32'h3);
    chk("arst_run", 32'(hrun), 32'h0);
    chk("arst_dram", dbase[31:0], 32'h0);
    chk("arst_entry", epc[63:32], 32'h0);
    chk("arst_rdata", rdata, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rdchk("gstat_after_rst", 16'h1000, 32'h0002_0300);

`ifdef BOOTCTRL_MH_TRACE_EN
    wr(16'h1010, 4'hF, 32'h1);
    pcs[0] = 32'h0; pcs[1] = 32'h4; pcs[2] = 32'h4; pcs[3] = 32'h8;
    for (int i = 0; i < 4; i++) begin
      lpc[31:0] = pcs[i]; pcv[0] = 1'b1;
      @(negedge clk);
    end
    pcv[0] = 1'b0;
    rdchk("tr_count3", 16'h1014, 32'd3);
    rdchk("tr_pop0", 16'h1018, 32'h0);
    rdchk("tr_pop1", 16'h1018, 32'h4);
    rdchk("tr_pop2", 16'h1018, 32'h8);
    rdchk("tr_pop_empty", 16'h1018, 32'h0);
    rdchk("tr_count0", 16'h1014, 32'd0);
    for (int i = 0; i < 20; i++) begin
      lpc[31:0] = 32'h100 + 32'(4 * i); pcv[0] = 1'b1;
      @(negedge clk);
    end
    pcv[0] = 1'b0;
    rdchk("tr_count_full", 16'h1014, 32'd16);
    rd(16'h1000, d);
    chk("tr_ovf_set", {30'b0, d[17:16]}, 32'h1);
    rdchk("tr_pop_oldest", 16'h1018, 32'h100);
    rdchk("tr_count15", 16'h1014, 32'd15);
    wr(16'h1010, 4'hF, 32'h101);
    rdchk("tr_clear_cnt", 16'h1014, 32'd0);
    rd(16'h1000, d);
    chk("tr_clear_flags", {30'b0, d[17:16]}, 32'h2);
    lpc[31:0] = 32'h500; pcv[0] = 1'b1;
    @(negedge clk);
    lpc[31:0] = 32'h504;
    rdaddr = 16'h1018; rden = 1'b1;
    @(negedge clk);
    rden = 1'b0; pcv[0] = 1'b0;
    chk("tr_pushpop_data", rdata, 32'h500);
    rdchk("tr_pushpop_cnt", 16'h1014, 32'd1);
    rdchk("tr_pushpop_next", 16'h1018, 32'h504);
`else
    wr(16'h1010, 4'hF, 32'h1);
    lpc[31:0] = 32'h40; pcv[0] = 1'b1;
    @(negedge clk);
    pcv[0] = 1'b0;
    rdchk("notr_ctrl", 16'h1010, 32'h0);
    rdchk("notr_count", 16'h1014, 32'h0);
    rdchk("notr_data", 16'h1018, 32'h0);
    rdchk("notr_gstat", 16'h1000, 32'h0002_0300);
`endif

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
